// File: rtl/alu_issue_stage.sv
// ID/EX issue stage ahead of the 32-bit ALU.
// Decodes RV32I into ALU controls, forwards operands, handles load-use stalls and flush.
module alu_issue_stage #(
  parameter bit          FWD_EN           = 1'b1,
  parameter int unsigned LOAD_USE_BUBBLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [31:0] id_instr,
  input  logic [31:0] id_pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        mem_fwd_we,
  input  logic [4:0]  mem_fwd_rd,
  input  logic [31:0] mem_fwd_data,
  input  logic        wb_fwd_we,
  input  logic [4:0]  wb_fwd_rd,
  input  logic [31:0] wb_fwd_data,
  input  logic        ex_ready,
  output logic        ex_valid,
  output logic [2:0]  alu_opcode,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic        alu_sub,
  output logic [4:0]  ex_rd,
  output logic        ex_we,
  output logic        ex_is_load,
  output logic        ex_is_store,
  output logic        ex_is_branch,
  output logic [2:0]  ex_funct3,
  output logic [31:0] ex_store_data,
  output logic        ex_illegal
);

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OPIMM  = 7'b0010011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011
  } opc_e;

  opc_e        opc;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_u;
  logic [31:0] rs1_val, rs2_val;

  assign opc   = opc_e'(id_instr[6:0]);
  assign rd    = id_instr[11:7];
  assign f3    = id_instr[14:12];
  assign rs1   = id_instr[19:15];
  assign rs2   = id_instr[24:20];
  assign imm_i = {{20{id_instr[31]}}, id_instr[31:20]};
  assign imm_s = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
  assign imm_u = {id_instr[31:12], 12'h000};

  // MEM result is younger than WB, so it takes priority.
  function automatic logic [31:0] fwd_sel(
    input logic [4:0]  r,
    input logic [31:0] rf,
    input logic        mwe,
    input logic [4:0]  mrd,
    input logic [31:0] mdata,
    input logic        wwe,
    input logic [4:0]  wrd,
    input logic [31:0] wdata
  );
    if (r == 5'd0)                  return '0;
    if (FWD_EN && mwe && mrd == r)  return mdata;
    if (FWD_EN && wwe && wrd == r)  return wdata;
    return rf;
  endfunction

  assign rs1_val = fwd_sel(rs1, rs1_data, mem_fwd_we, mem_fwd_rd, mem_fwd_data,
                           wb_fwd_we, wb_fwd_rd, wb_fwd_data);
  assign rs2_val = fwd_sel(rs2, rs2_data, mem_fwd_we, mem_fwd_rd, mem_fwd_data,
                           wb_fwd_we, wb_fwd_rd, wb_fwd_data);

  logic [2:0]  d_opcode;
  logic        d_sub, d_we, d_is_load, d_is_store, d_is_branch, d_illegal;
  logic [31:0] d_op1, d_op2;
  logic [4:0]  d_rd;
  logic        rs1_used, rs2_used;

  always_comb begin
    d_opcode    = '0;
    d_sub       = 1'b0;
    d_op1       = '0;
    d_op2       = '0;
    d_rd        = '0;
    d_we        = 1'b0;
    d_is_load   = 1'b0;
    d_is_store  = 1'b0;
    d_is_branch = 1'b0;
    d_illegal   = 1'b0;
    rs1_used    = 1'b0;
    rs2_used    = 1'b0;
    case (opc)
      OPC_OP: begin
        d_opcode = f3;
        d_sub    = id_instr[30] && (f3 == 3'b000 || f3 == 3'b101);
        d_op1    = rs1_val;
        d_op2    = rs2_val;
        d_rd     = rd;
        d_we     = 1'b1;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OPC_OPIMM: begin
        d_opcode = f3;
        d_sub    = id_instr[30] && (f3 == 3'b101);
        d_op1    = rs1_val;
        d_op2    = imm_i;
        d_rd     = rd;
        d_we     = 1'b1;
        rs1_used = 1'b1;
      end
      OPC_LUI: begin
        d_op2 = imm_u;
        d_rd  = rd;
        d_we  = 1'b1;
      end
      OPC_AUIPC: begin
        d_op1 = id_pc;
        d_op2 = imm_u;
        d_rd  = rd;
        d_we  = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        d_op1    = id_pc;
        d_op2    = 32'd4;
        d_rd     = rd;
        d_we     = 1'b1;
        rs1_used = (opc == OPC_JALR);
      end
      OPC_LOAD: begin
        d_op1     = rs1_val;
        d_op2     = imm_i;
        d_rd      = rd;
        d_we      = 1'b1;
        d_is_load = 1'b1;
        rs1_used  = 1'b1;
      end
      OPC_STORE: begin
        d_op1      = rs1_val;
        d_op2      = imm_s;
        d_is_store = 1'b1;
        rs1_used   = 1'b1;
        rs2_used   = 1'b1;
      end
      OPC_BRANCH: begin
        d_op1       = rs1_val;
        d_op2       = rs2_val;
        d_is_branch = 1'b1;
        rs1_used    = 1'b1;
        rs2_used    = 1'b1;
        case (f3[2:1])
          2'b00:   d_sub     = 1'b1;
          2'b10:   d_opcode  = 3'b010;
          2'b11:   d_opcode  = 3'b011;
          default: d_illegal = 1'b1;
        endcase
      end
      default: d_illegal = 1'b1;
    endcase
  end

  logic advance, hazard, hazard_raw;

  assign hazard_raw = ex_valid && ex_is_load && (ex_rd != 5'd0) &&
                      ((rs1_used && ex_rd == rs1) || (rs2_used && ex_rd == rs2));
  assign hazard     = (LOAD_USE_BUBBLES != 0) && hazard_raw;
  assign advance    = !ex_valid || ex_ready;
  assign id_ready   = advance && !hazard && !flush;

  // A bubble only clears ex_valid; the payload holds its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      alu_opcode    <= '0;
      alu_op1       <= '0;
      alu_op2       <= '0;
      alu_sub       <= 1'b0;
      ex_rd         <= '0;
      ex_we         <= 1'b0;
      ex_is_load    <= 1'b0;
      ex_is_store   <= 1'b0;
      ex_is_branch  <= 1'b0;
      ex_funct3     <= '0;
      ex_store_data <= '0;
      ex_illegal    <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (advance) begin
      ex_valid <= id_valid && id_ready;
      if (id_valid && id_ready) begin
        alu_opcode    <= d_opcode;
        alu_op1       <= d_op1;
        alu_op2       <= d_op2;
        alu_sub       <= d_sub;
        ex_rd         <= d_rd;
        ex_we         <= d_we && (d_rd != 5'd0);
        ex_is_load    <= d_is_load;
        ex_is_store   <= d_is_store;
        ex_is_branch  <= d_is_branch;
        ex_funct3     <= f3;
        ex_store_data <= rs2_val;
        ex_illegal    <= d_illegal;
      end
    end
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX pipeline stage directly upstream of the 32-bit ALU.
- Decodes RV32I instruction fields into the ALU control set (opcode[2:0], sub, op1, op2).
- Resolves operand forwarding from the MEM and WB stages.
- Detects load-use hazards and registers everything into the EX stage behind a valid/ready handshake with stall and flush.

Parameters:
- FWD_EN, 1, 1 = forwarding muxes enabled; 0 = always use register-file data.
- LOAD_USE_BUBBLES, 1, number of bubble cycles inserted on a load-use hazard (0 or 1).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  kill the EX-stage entry and refuse the current ID instruction this cycle
- id_valid  in  1  decode stage presents an instruction
- id_ready  out  1  stage accepts the ID instruction this cycle
- id_instr  in  32  raw instruction
- id_pc  in  32  instruction PC
- rs1_data  in  32  register-file read, rs1 = id_instr[19:15]
- rs2_data  in  32  register-file read, rs2 = id_instr[24:20]
- mem_fwd_we  in  1  MEM stage will write rd
- mem_fwd_rd  in  5  MEM destination register
- mem_fwd_data  in  32  MEM result
- wb_fwd_we  in  1  WB stage writes rd
- wb_fwd_rd  in  5  WB destination register
- wb_fwd_data  in  32  WB result
- ex_ready  in  1  EX consumes the current entry this cycle
- ex_valid  out  1  EX entry valid
- alu_opcode  out  3  ALU function select
- alu_op1  out  32  ALU operand 1
- alu_op2  out  32  ALU operand 2
- alu_sub  out  1  ALU subtract / arithmetic-shift select
- ex_rd  out  5  destination register
- ex_we  out  1  instruction writes rd
- ex_is_load  out  1  load; ALU computes the address
- ex_is_store  out  1  store; ALU computes the address
- ex_is_branch  out  1  conditional branch; ALU computes the compare
- ex_funct3  out  3  raw funct3, passed on to MEM/branch logic
- ex_store_data  out  32  forwarded rs2 value
- ex_illegal  out  1  unsupported opcode

Behaviour:
- Reset (async, rst_n=0): all outputs 0.
- Handshake:
  - advance = !ex_valid || ex_ready.
  - id_ready = advance && !hazard && !flush.
  - On a clk edge with advance=1, the EX registers load the decoded ID instruction if id_valid && id_ready; otherwise they load a bubble (ex_valid=0, all other EX outputs hold).
  - With advance=0, all EX outputs hold.
- Flush: synchronous. Next edge ex_valid=0 regardless of ex_ready. The ID instruction is not accepted.
- Hazard (LOAD_USE_BUBBLES=1):
  - hazard = ex_valid && ex_is_load && ex_rd!=0 && (ex_rd==rs1 used || ex_rd==rs2 used).
  - rs2 counts as "used" only for OP, STORE and BRANCH instructions.
  - Exactly one bubble is inserted, then the instruction issues using the MEM forward.
- Forwarding, per source operand:
  - reg==0 → 0.
  - Otherwise, if mem_fwd_we && mem_fwd_rd==reg → mem_fwd_data.
  - Otherwise, if wb_fwd_we && wb_fwd_rd==reg → wb_fwd_data.
  - Otherwise, register-file data.
  - MEM has priority over WB.
- Decode (imm = standard I/S/B/U/J sign-extended):
  - OP (0110011): opcode=funct3; sub=instr[30] only for funct3 000/101; op1=rs1; op2=rs2.
  - OP-IMM (0010011): opcode=funct3; sub=instr[30] only for funct3 101, else 0; op1=rs1; op2=I-imm.
  - LUI: opcode=000, sub=0, op1=0, op2=U-imm.
  - AUIPC: opcode=000, sub=0, op1=pc, op2=U-imm.
  - JAL and JALR: opcode=000, op1=pc, op2=4, ex_we=1 (link value only).
  - LOAD: opcode=000, op1=rs1, op2=I-imm, we=1, is_load=1.
  - STORE: opcode=000, op1=rs1, op2=S-imm, we=0, is_store=1, store_data=rs2.
  - BRANCH: op1=rs1, op2=rs2, we=0, is_branch=1.
    - funct3 000/001 → opcode 000, sub=1 (compare uses z).
    - funct3 100/101 → opcode 010.
    - funct3 110/111 → opcode 011.
    - funct3 010/011 → ex_illegal=1.
  - Any other opcode: ex_illegal=1, ex_we=0, and the ALU fields are 0.
- ex_we is forced to 0 when rd==0.
- Latency: 1 cycle from ID acceptance to ex_valid.
- Simultaneous flush and hazard: flush wins.
- Reset mid-stall: the EX entry is lost; ex_valid=0 immediately.

Test Plan:
- Reset, then ADDI x1,x0,5 (0x00500093), ex_ready=1 → next cycle ex_valid=1, opcode=000, op1=0, op2=5, sub=0, ex_rd=1, ex_we=1.
- SRAI x2,x1,3 with instr[30]=1, then SUB → both give sub=1; ADDI with imm bit 10 set → sub=0.
- ADD x3,x1,x2 with mem_fwd (x1=0x11) and wb_fwd (x1=0x22, x2=0x33) both active → op1=0x11, op2=0x33. Same case with rd=x0 sources → operand 0.
- LW x5 followed by ADD x6,x5,x5 → id_ready=0 for 1 cycle, EX bubble (ex_valid=0), then ADD issues with op1=op2=mem_fwd_data.
- ex_ready=0 for 3 cycles with id_valid=1 → EX outputs stable, id_ready=0. Asserting flush in cycle 2 → ex_valid=0 next edge and the ID instruction is not accepted.
- BLTU x1,x2 → opcode=011, is_branch=1, we=0. Opcode 0x7F → ex_illegal=1, we=0. rst_n low mid-stall → all outputs 0 asynchronously.
